// File: rtl/riscv_hazard_pkg.sv
// riscv_hazard_pkg: forwarding encodings, multi-cycle FSM state encoding and forwarding helper.
// Rev 1.0
`default_nettype none

package riscv_hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] MC_IDLE = 2'b00;
  localparam logic [1:0] MC_BUSY = 2'b01;
  localparam logic [1:0] MC_DONE = 2'b10;

  // M is the younger producer, so it wins over W; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       wr_m,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_mc_seq.sv
// riscv_mc_seq: holds the E stage for MC_LATENCY-1 cycles of a multi-cycle op, then flags completion.
// Rev 1.0
`default_nettype none

module riscv_mc_seq
  import riscv_hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mc_op_i,
  output logic mc_stall_o,
  output logic mc_start_o,
  output logic mc_done_o
);

  localparam int CW = $clog2(MC_LATENCY);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MC_IDLE: begin
        if (mc_op_i) begin
          state_d = MC_BUSY;
          // IDLE and DONE each account for one cycle of occupancy, BUSY for the rest.
          cnt_d   = CW'(MC_LATENCY - 3);
        end
      end
      MC_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = MC_DONE;
        end
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mc_start_o = (state_q == MC_IDLE) && mc_op_i;
  assign mc_stall_o = mc_start_o || (state_q == MC_BUSY);
  assign mc_done_o  = (state_q == MC_DONE);

endmodule

`default_nettype wire

// File: rtl/riscv_hazard_unit.sv
// riscv_hazard_unit: forwarding, load-use/branch stall-flush control and multi-cycle E sequencing.
// Rev 1.0 -- optional statistics counters enabled by defining RISCV_HAZARD_STATS_EN.
`default_nettype none

module riscv_hazard_unit
  import riscv_hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_rs1_d,
  input  logic [4:0]       i_rs2_d,
  input  logic [4:0]       i_rs1_e,
  input  logic [4:0]       i_rs2_e,
  input  logic [4:0]       i_rd_e,
  input  logic [4:0]       i_rd_m,
  input  logic [4:0]       i_rd_w,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  input  logic             i_load_e,
  input  logic             i_pc_src_e,
  input  logic             i_mc_op_e,
  output logic [1:0]       o_forward_ae,
  output logic [1:0]       o_forward_be,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_m,
  output logic             o_mc_start,
  output logic             o_mc_done,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic lw_stall;
  logic mc_stall;

  assign o_forward_ae = fwd_sel(i_rs1_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);
  assign o_forward_be = fwd_sel(i_rs2_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);

  assign lw_stall = i_load_e && (i_rd_e != 5'd0) &&
                    ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

  riscv_mc_seq #(
    .MC_LATENCY (MC_LATENCY)
  ) u_mc_seq (
    .clk_i      (i_clk),
    .rst_ni     (i_rstn),
    .mc_op_i    (i_mc_op_e),
    .mc_stall_o (mc_stall),
    .mc_start_o (o_mc_start),
    .mc_done_o  (o_mc_done)
  );

  // While E is held no bubble may enter E; M takes the bubbles instead.
  assign o_stall_f = lw_stall || mc_stall;
  assign o_stall_d = lw_stall || mc_stall;
  assign o_stall_e = mc_stall;
  assign o_flush_d = i_pc_src_e && !mc_stall;
  assign o_flush_e = (lw_stall || i_pc_src_e) && !mc_stall;
  assign o_flush_m = mc_stall;

`ifdef RISCV_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stall_f) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (o_flush_e) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_hazard_unit.sv
// tb_riscv_hazard_unit: directed and randomized checks of riscv_hazard_unit against a cycle-age model.
// Rev 1.0
`default_nettype none

module tb_riscv_hazard_unit;

  localparam int L  = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          wm, ww, load_e, pc_src, mc_op;
  logic [1:0]    fa, fb;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_start, mc_done;
  logic [CW-1:0] stall_cnt, flush_cnt;

  riscv_hazard_unit #(.MC_LATENCY(L), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
    .i_reg_write_m(wm), .i_reg_write_w(ww),
    .i_load_e(load_e), .i_pc_src_e(pc_src), .i_mc_op_e(mc_op),
    .o_forward_ae(fa), .o_forward_be(fb),
    .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e),
    .o_flush_d(flush_d), .o_flush_e(flush_e), .o_flush_m(flush_m),
    .o_mc_start(mc_start), .o_mc_done(mc_done),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: age = cycles the current multi-cycle op has spent in E (-1 when none).
  int            age = -1;
  int            eff;
  logic [CW-1:0] m_stall_cnt, m_flush_cnt;
  logic [1:0]    e_fa, e_fb;
  logic          e_lw, e_mcs, e_sf, e_fd, e_fe, e_start, e_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (wm && rd_m != 0 && rd_m == rs) return 2'd2;
    if (ww && rd_w != 0 && rd_w == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_eval();
    eff     = (age < 0 && mc_op) ? 0 : age;
    e_mcs   = (eff >= 0) && (eff <= L - 2);
    e_start = (eff == 0);
    e_done  = (eff == L - 1);
    e_lw    = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    e_sf    = e_lw || e_mcs;
    e_fd    = pc_src && !e_mcs;
    e_fe    = (e_lw || pc_src) && !e_mcs;
    e_fa    = ref_fwd(rs1_e);
    e_fb    = ref_fwd(rs2_e);
  endtask

  task automatic check_model();
    model_eval();
    chk("fwd_a",    64'(fa),       64'(e_fa));
    chk("fwd_b",    64'(fb),       64'(e_fb));
    chk("stall_f",  64'(stall_f),  64'(e_sf));
    chk("stall_d",  64'(stall_d),  64'(e_sf));
    chk("stall_e",  64'(stall_e),  64'(e_mcs));
    chk("flush_d",  64'(flush_d),  64'(e_fd));
    chk("flush_e",  64'(flush_e),  64'(e_fe));
    chk("flush_m",  64'(flush_m),  64'(e_mcs));
    chk("mc_start", 64'(mc_start), 64'(e_start));
    chk("mc_done",  64'(mc_done),  64'(e_done));
`ifdef RISCV_HAZARD_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
`else
    chk("stall_cnt", 64'(stall_cnt), 64'd0);
    chk("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
  endtask

  task automatic model_step();
    if (rstn) begin
      if (e_sf) m_stall_cnt = m_stall_cnt + 1;
      if (e_fe) m_flush_cnt = m_flush_cnt + 1;
      age = (eff < 0 || eff == L - 1) ? -1 : eff + 1;
    end
  endtask

  task automatic tick_pre();
    @(negedge clk);
  endtask

  task automatic tick_post();
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    wm = 0; ww = 0; load_e = 0; pc_src = 0; mc_op = 0;
  endtask

  task automatic model_reset();
    age = -1;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    model_reset();
    #2;
    chk("rst_fwd_a",   64'(fa),       64'd0);
    chk("rst_stall_f", 64'(stall_f),  64'd0);
    chk("rst_stall_e", 64'(stall_e),  64'd0);
    chk("rst_flush_e", 64'(flush_e),  64'd0);
    chk("rst_mc_done", 64'(mc_done),  64'd0);
    chk("rst_cnt",     64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Forwarding priority and x0
    rd_m = 5; wm = 1; rd_w = 5; ww = 1; rs1_e = 5;
    tick_pre(); chk("fwd_m_wins", 64'(fa), 64'd2); tick_post();
    wm = 0;
    tick_pre(); chk("fwd_w", 64'(fa), 64'd1); tick_post();
    rd_m = 0; rd_w = 0; rs1_e = 0; wm = 1; ww = 1;
    tick_pre(); chk("fwd_x0", 64'(fa), 64'd0); tick_post();

    // Load-use
    idle(); load_e = 1; rd_e = 7; rs2_d = 7;
    tick_pre();
    chk("lw_stall_f", 64'(stall_f), 64'd1);
    chk("lw_flush_e", 64'(flush_e), 64'd1);
    chk("lw_stall_e", 64'(stall_e), 64'd0);
    tick_post();
    rd_e = 0; rs2_d = 0;
    tick_pre(); chk("lw_x0_nostall", 64'(stall_f), 64'd0); tick_post();

    // Taken branch
    idle(); pc_src = 1;
    tick_pre();
    chk("br_flush_d", 64'(flush_d), 64'd1);
    chk("br_flush_e", 64'(flush_e), 64'd1);
    chk("br_stall_f", 64'(stall_f), 64'd0);
    tick_post();

    // Stats sequence from a clean reset: one mc op plus one branch
    idle(); rstn = 1'b0; model_reset();
    @(posedge clk); #1; rstn = 1'b1;
    mc_op = 1;
    for (int k = 0; k < L; k++) begin
      tick_pre();
      chk("mc_stall_e", 64'(stall_e), 64'(k != L - 1));
      chk("mc_flush_m", 64'(flush_m), 64'(k != L - 1));
      chk("mc_start",   64'(mc_start), 64'(k == 0));
      chk("mc_done",    64'(mc_done),  64'(k == L - 1));
      tick_post();
    end
    mc_op = 0; pc_src = 1;
    tick();
    pc_src = 0;
    tick_pre();
`ifdef RISCV_HAZARD_STATS_EN
    chk("stats_stall", 64'(stall_cnt), 64'd3);
    chk("stats_flush", 64'(flush_cnt), 64'd1);
`else
    chk("stats_stall", 64'(stall_cnt), 64'd0);
    chk("stats_flush", 64'(flush_cnt), 64'd0);
`endif
    tick_post();

    // Back-to-back multi-cycle ops
    mc_op = 1;
    for (int k = 0; k < 2 * L; k++) begin
      tick_pre();
      chk("b2b_stall_f", 64'(stall_f), 64'((k % L) != L - 1));
      chk("b2b_done",    64'(mc_done), 64'((k % L) == L - 1));
      tick_post();
    end

    // Multi-cycle op with concurrent load-use in D
    load_e = 1; rd_e = 9; rs1_d = 9;
    for (int k = 0; k < L; k++) begin
      tick_pre();
      if (k != L - 1) begin
        chk("mclw_stall_e", 64'(stall_e), 64'd1);
        chk("mclw_flush_e", 64'(flush_e), 64'd0);
      end
      tick_post();
    end

    // Reset in the middle of an op
    idle(); mc_op = 1;
    tick();
    idle(); rstn = 1'b0; model_reset();
    tick_pre();
    chk("midrst_stall_e", 64'(stall_e), 64'd0);
    chk("midrst_flush_m", 64'(flush_m), 64'd0);
    chk("midrst_done",    64'(mc_done), 64'd0);
    tick_post();
    rstn = 1'b1;
    tick_pre(); chk("midrst_idle", 64'(stall_e), 64'd0); tick_post();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rs1_d  = 5'($urandom_range(0, 7));
      rs2_d  = 5'($urandom_range(0, 7));
      rs1_e  = 5'($urandom_range(0, 7));
      rs2_e  = 5'($urandom_range(0, 7));
      rd_e   = 5'($urandom_range(0, 7));
      rd_m   = 5'($urandom_range(0, 7));
      rd_w   = 5'($urandom_range(0, 7));
      wm     = 1'($urandom_range(0, 1));
      ww     = 1'($urandom_range(0, 1));
      load_e = 1'($urandom_range(0, 1));
      mc_op  = (age >= 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      pc_src = (age < 0 && !mc_op) ? 1'($urandom_range(0, 5) == 0) : 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
